// File: rtl/dram_mux_model.sv
module dram_mux_model #(
  parameter int    DW        = 4,
  parameter int    ROW_W     = 8,
  parameter int    COL_W     = 6,
  parameter int    COL_LSB   = 1,
  parameter int    AW_IN     = 8,
  parameter int    RD_LAT    = 1,
  parameter string INIT_FILE = ""
) (
  input  logic             i_MCLK,
  input  logic             i_RST_n,
  input  logic [AW_IN-1:0] i_ADDR,
  input  logic [DW-1:0]    i_DIN,
  input  logic             i_RAS_n,
  input  logic             i_CAS_n,
  input  logic             i_WR_n,
  input  logic             i_RD_n,
  output logic [DW-1:0]    o_DOUT,
  output logic             o_DOUT_VALID,
  output logic [ROW_W-1:0] o_REF_CNT,
  output logic             o_PROT_ERR
);

  localparam int AW    = ROW_W + COL_W;
  localparam int DEPTH = 1 << AW;

  typedef enum logic [1:0] {
    S_IDLE,
    S_ROW,
    S_COL,
    S_CBR
  } state_t;

  state_t            state;
  state_t            state_nx;
  logic              ras_q;
  logic              cas_q;
  logic [ROW_W-1:0]  row_q;
  logic [COL_W-1:0]  col_q;
  logic              col_done;

  logic              ras_fall;
  logic              cas_fall;
  logic              cas_rise;
  logic [ROW_W-1:0]  addr_row;
  logic [COL_W-1:0]  addr_col;

  logic              latch_row;
  logic              latch_col;
  logic              ref_inc;
  logic              acc_ok;
  logic [COL_W-1:0]  acc_col;
  logic [AW-1:0]     mem_addr;
  logic              wr_en;
  logic              rd_en;
  logic              prot_hit;

  logic [DW-1:0]     mem [DEPTH];
  logic [DW-1:0]     pipe_d [RD_LAT];
  logic              pipe_v [RD_LAT];

  assign ras_fall = ras_q & ~i_RAS_n;
  assign cas_fall = cas_q & ~i_CAS_n;
  assign cas_rise = ~cas_q & i_CAS_n;
  assign addr_row = i_ADDR[ROW_W-1:0];
  assign addr_col = i_ADDR[COL_LSB+COL_W-1:COL_LSB];

  always_comb begin
    state_nx  = state;
    latch_row = 1'b0;
    latch_col = 1'b0;
    ref_inc   = 1'b0;
    acc_ok    = 1'b0;
    acc_col   = col_q;
    if (i_RAS_n) begin
      state_nx = S_IDLE;
      if (state == S_ROW && !col_done) begin
        ref_inc = 1'b1;
      end
      if (state == S_COL) begin
        acc_ok = 1'b1;
      end
    end else begin
      unique case (state)
        S_IDLE: begin
          if (ras_fall) begin
            if (!i_CAS_n) begin
              state_nx = S_CBR;
              ref_inc  = 1'b1;
            end else begin
              state_nx  = S_ROW;
              latch_row = 1'b1;
            end
          end
        end
        S_ROW: begin
          if (cas_fall) begin
            // Column taken straight from the bus so the strobe-cycle access is not delayed.
            state_nx  = S_COL;
            latch_col = 1'b1;
            acc_ok    = 1'b1;
            acc_col   = addr_col;
          end
        end
        S_COL: begin
          acc_ok = 1'b1;
          if (cas_rise) begin
            state_nx = S_ROW;
          end
        end
        S_CBR: begin
          state_nx = S_CBR;
        end
        default: state_nx = S_IDLE;
      endcase
    end
  end

  assign mem_addr = {acc_col, row_q};
  assign wr_en    = acc_ok & ~i_WR_n;
  assign rd_en    = acc_ok & ~i_RD_n;
  assign prot_hit = ~acc_ok & (~i_WR_n | ~i_RD_n);

  always_ff @(posedge i_MCLK or negedge i_RST_n) begin
    if (!i_RST_n) begin
      state      <= S_IDLE;
      ras_q      <= 1'b1;
      cas_q      <= 1'b1;
      row_q      <= '0;
      col_q      <= '0;
      col_done   <= 1'b0;
      o_REF_CNT  <= '0;
      o_PROT_ERR <= 1'b0;
    end else begin
      state <= state_nx;
      ras_q <= i_RAS_n;
      cas_q <= i_CAS_n;
      if (latch_row) begin
        row_q    <= addr_row;
        col_done <= 1'b0;
      end
      if (latch_col) begin
        col_q    <= addr_col;
        col_done <= 1'b1;
      end
      if (ref_inc) begin
        o_REF_CNT <= o_REF_CNT + 1'b1;
      end
      if (prot_hit) begin
        o_PROT_ERR <= 1'b1;
      end
    end
  end

  always_ff @(posedge i_MCLK) begin
    if (wr_en) begin
      mem[mem_addr] <= i_DIN;
    end
  end

  always_ff @(posedge i_MCLK or negedge i_RST_n) begin
    if (!i_RST_n) begin
      for (int unsigned i = 0; i < RD_LAT; i++) begin
        pipe_d[i] <= '0;
        pipe_v[i] <= 1'b0;
      end
      o_DOUT       <= '0;
      o_DOUT_VALID <= 1'b0;
    end else begin
      pipe_d[0] <= mem[mem_addr];
      pipe_v[0] <= rd_en;
      for (int unsigned i = 1; i < RD_LAT; i++) begin
        pipe_d[i] <= pipe_d[i-1];
        pipe_v[i] <= pipe_v[i-1];
      end
      o_DOUT_VALID <= pipe_v[RD_LAT-1];
      if (pipe_v[RD_LAT-1]) begin
        o_DOUT <= pipe_d[RD_LAT-1];
      end
    end
  end

endmodule

// File: tb/tb_dram_mux_model.sv
// Scoreboard bench for dram_mux_model: two instances share the strobe and
// address bus (DW=4/RD_LAT=1 and DW=8/RD_LAT=3); each has its own reset.
module tb_dram_mux_model;

    logic       clk = 1'b0;
    logic       rst1_n, rst3_n;
    logic       ras, cas, wr, rd;
    logic [7:0] addr, din;
    logic [3:0] dout1;
    logic [7:0] dout3;
    logic       v1, v3, perr1, perr3;
    logic [7:0] refc1, refc3;

    always #5 clk = ~clk;

    dram_mux_model #(.DW(4), .RD_LAT(1)) dut1 (
        .i_MCLK(clk), .i_RST_n(rst1_n), .i_ADDR(addr), .i_DIN(din[3:0]),
        .i_RAS_n(ras), .i_CAS_n(cas), .i_WR_n(wr), .i_RD_n(rd),
        .o_DOUT(dout1), .o_DOUT_VALID(v1), .o_REF_CNT(refc1), .o_PROT_ERR(perr1));

    dram_mux_model #(.DW(8), .RD_LAT(3)) dut3 (
        .i_MCLK(clk), .i_RST_n(rst3_n), .i_ADDR(addr), .i_DIN(din),
        .i_RAS_n(ras), .i_CAS_n(cas), .i_WR_n(wr), .i_RD_n(rd),
        .o_DOUT(dout3), .o_DOUT_VALID(v3), .o_REF_CNT(refc3), .o_PROT_ERR(perr3));

    typedef struct {
        logic [7:0] d;
        int         due;
    } exp_t;

    exp_t       q1[$], q3[$];
    exp_t       m1, m3;
    logic [7:0] mdl [int];
    int         cyc = 0;
    int         n_pass = 0, n_total = 0;
    int         ref1 = 0, ref3 = 0;
    bit         prot1 = 0, prot3 = 0;
    logic [7:0] last1 = 0, last3 = 0;
    int         cur_row = 0, cur_col = 0;
    bit         col_seen = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input int act, input int exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0h, required %0h", nm, act, exp);
    endtask

    // Monitors: every valid pulse must match the oldest expected read, on
    // exactly the cycle it is due.
    always @(negedge clk) begin
        if (v1) begin
            n_total++;
            if (q1.size() == 0) begin
                $display("FAIL dut1_spurious_valid: got %0h, required no pulse", dout1);
            end else begin
                m1 = q1.pop_front();
                if (dout1 == m1.d[3:0] && m1.due == cyc) n_pass++;
                else $display("FAIL dut1_read: got %0h at cycle %0d, required %0h at cycle %0d",
                              dout1, cyc, m1.d[3:0], m1.due);
            end
        end else if (q1.size() > 0 && q1[0].due < cyc) begin
            n_total++;
            m1 = q1.pop_front();
            $display("FAIL dut1_missing_valid: got no pulse, required %0h at cycle %0d", m1.d[3:0], m1.due);
        end
        if (v3) begin
            n_total++;
            if (q3.size() == 0) begin
                $display("FAIL dut3_spurious_valid: got %0h, required no pulse", dout3);
            end else begin
                m3 = q3.pop_front();
                if (dout3 == m3.d && m3.due == cyc) n_pass++;
                else $display("FAIL dut3_read: got %0h at cycle %0d, required %0h at cycle %0d",
                              dout3, cyc, m3.d, m3.due);
            end
        end else if (q3.size() > 0 && q3[0].due < cyc) begin
            n_total++;
            m3 = q3.pop_front();
            $display("FAIL dut3_missing_valid: got no pulse, required %0h at cycle %0d", m3.d, m3.due);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic int key_of(input int c);
        return c * 256 + cur_row;
    endfunction

    // One access cycle at the current row/column; reads expect the word as
    // it was before any write on the same cycle.
    task automatic do_access(input bit w, input logic [7:0] d, input bit r);
        exp_t e;
        int   k;
        wr  = !w;
        rd  = !r;
        din = d;
        tick();
        k = key_of(cur_col);
        if (r) begin
            e.d   = mdl.exists(k) ? mdl[k] : 8'h00;
            e.due = cyc + 1;
            q1.push_back(e);
            last1 = e.d;
            if (rst3_n) begin
                e.due = cyc + 3;
                q3.push_back(e);
                last3 = e.d;
            end
        end
        if (w) mdl[k] = d;
        wr = 1'b1;
        rd = 1'b1;
    endtask

    task automatic open_row(input int r);
        addr = r[7:0];
        ras  = 1'b0;
        tick();
        cur_row  = r;
        col_seen = 0;
    endtask

    task automatic cas_down(input int c, input bit w, input logic [7:0] d, input bit r);
        logic [7:0] a;
        a       = 8'(c);
        addr    = a << 1;
        cas     = 1'b0;
        cur_col = c;
        col_seen = 1;
        do_access(w, d, r);
    endtask

    task automatic cas_up();
        cas = 1'b1;
        tick();
    endtask

    task automatic close_row();
        ras = 1'b1;
        cas = 1'b1;
        tick();
        if (!col_seen) begin
            ref1++;
            if (rst3_n) ref3++;
        end
    endtask

    task automatic cbr_cycle();
        cas = 1'b0;
        tick();
        ras = 1'b0;
        tick();
        ref1++;
        if (rst3_n) ref3++;
        ras = 1'b1;
        cas = 1'b1;
        tick();
    endtask

    task automatic chk_status(input string tag);
        chk({tag, "_ref1"}, refc1, ref1 & 255);
        chk({tag, "_ref3"}, refc3, ref3 & 255);
        chk({tag, "_perr1"}, perr1, prot1);
        chk({tag, "_perr3"}, perr3, prot3);
    endtask

    initial begin
        int c, k, np, nx;
        bit w, r;
        logic [7:0] d;

        rst1_n = 0; rst3_n = 0;
        ras = 1; cas = 1; wr = 1; rd = 1; addr = 0; din = 0;
        repeat (3) tick();
        chk("rst_dout1", dout1, 0);
        chk("rst_v1", v1, 0);
        chk("rst_dout3", dout3, 0);
        chk("rst_v3", v3, 0);
        chk_status("rst");
        rst1_n = 1; rst3_n = 1;
        tick();

        // Basic write then read at word 0x525
        open_row(8'h25);
        cas_down(5, 1, 8'h09, 0);
        do_access(0, 0, 1);
        close_row();
        chk("word_0x525", dut1.mem[14'h525], 9);
        chk("word3_0x525", dut3.mem[14'h525], 9);

        // Page mode: three column cycles in one row, read back in a new page
        open_row(8'h10);
        for (int i = 0; i < 3; i++) begin
            cas_down(i, 1, 8'(i + 1), 0);
            cas_up();
        end
        close_row();
        open_row(8'h10);
        for (int i = 0; i < 3; i++) begin
            cas_down(i, 0, 0, 1);
            cas_up();
        end
        close_row();

        // Read-modify-write
        open_row(8'h40);
        cas_down(7, 1, 8'h04, 0);
        do_access(1, 8'h0C, 1);
        do_access(0, 0, 1);
        close_row();

        // Back-to-back RMW reads: each returns the previous cycle's write
        open_row(8'h41);
        cas_down(3, 1, 8'hA1, 0);
        do_access(1, 8'hB2, 1);
        do_access(1, 8'hC3, 1);
        do_access(1, 8'hD4, 1);
        do_access(1, 8'hE5, 1);
        close_row();
        repeat (4) tick();
        chk("hold_dout1", dout1, last1[3:0]);
        chk("hold_dout3", dout3, last3);
        chk_status("b2b");

        // Protocol error: access in ROW state is ignored
        open_row(8'h25);
        addr = 8'h25; din = 8'hFF; wr = 0;
        tick();
        wr = 1;
        prot1 = 1; prot3 = 1;
        chk_status("prot_wr");
        rd = 0;
        tick();
        rd = 1;
        cas_down(5, 0, 0, 1);
        close_row();
        chk_status("prot_sticky");

        // CAS-before-RAS refresh
        cbr_cycle();
        chk_status("cbr");
        open_row(8'h25);
        cas_down(5, 0, 0, 1);
        close_row();

        // RAS-only refresh, wraps the counter
        for (int i = 0; i < 256; i++) begin
            open_row(i);
            close_row();
        end
        chk_status("ras_only_wrap");

        // Randomized page cycles against the model
        repeat (40) begin
            open_row($urandom_range(0, 255));
            np = $urandom_range(1, 3);
            for (int p = 0; p < np; p++) begin
                c = $urandom_range(0, 63);
                k = key_of(c);
                w = 1'($urandom_range(0, 1));
                d = 8'($urandom);
                cas_down(c, w, d, mdl.exists(k) ? 1'($urandom_range(0, 1)) : 1'b0);
                nx = $urandom_range(0, 2);
                for (int x = 0; x < nx; x++) begin
                    w = 1'($urandom_range(0, 1));
                    d = 8'($urandom);
                    do_access(w, d, mdl.exists(k) ? 1'($urandom_range(0, 1)) : 1'b0);
                end
                if (p < np - 1) cas_up();
            end
            close_row();
        end
        repeat (5) tick();
        chk_status("random");

        // Reset dut3 with two reads in flight: nothing may come out
        open_row(8'h40);
        cas_down(7, 0, 0, 1);
        do_access(0, 0, 1);
        rst3_n = 0;
        q3.delete();
        ref3 = 0; prot3 = 0; last3 = 0;
        close_row();
        repeat (2) tick();
        rst3_n = 1;
        repeat (5) tick();
        chk("rst_mid_dout3", dout3, 0);
        chk_status("rst_mid");

        repeat (6) tick();
        chk("q1_drained", q1.size(), 0);
        chk("q3_drained", q3.size(), 0);

        // Only reset clears the sticky flag
        rst1_n = 0;
        #1;
        chk("final_perr1", perr1, 0);
        chk("final_ref1", refc1, 0);
        chk("final_dout1", dout1, 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
